// File: rtl/lin_buff_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lin_buff_ctrl : frame sequencer around lin_buff; drops priming kernels,
//                 tags row-wrapped kernels as border and flags the last one.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module lin_buff_ctrl #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 6,
  parameter int KERNEL_WIDTH = BLOCK_WIDTH * BLOCK_HEIGHT * PIXEL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PIXEL_WIDTH-1:0]  s_pixel,
  output logic                    lb_p_valid,
  input  logic                    lb_p_ready,
  output logic [PIXEL_WIDTH-1:0]  lb_pixel,
  input  logic                    lb_k_valid,
  output logic                    lb_k_ready,
  input  logic [KERNEL_WIDTH-1:0] lb_kernel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [KERNEL_WIDTH-1:0] m_kernel,
  output logic                    m_border,
  output logic                    m_last
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] FWD_ROW     = ROW_W'(BLOCK_HEIGHT - 1);
  localparam logic [COL_W-1:0] BORDER_COLS = COL_W'(BLOCK_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ONE     = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE     = ROW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [ROW_W-1:0] in_row_q, in_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic             frame_done_q, frame_done_d;

  logic run;
  logic active;
  logic drop;
  logic in_hs;
  logic out_hs;
  logic in_at_last;
  logic out_at_last;

  assign run         = (state_q == S_RUN);
  assign active      = run || (state_q == S_DRAIN);
  assign drop        = (out_row_q < FWD_ROW);
  assign in_at_last  = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign out_at_last = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);

  // Input side is a pure gate: no storage between source and lin_buff.
  assign lb_pixel   = s_pixel;
  assign lb_p_valid = s_valid & run;
  assign s_ready    = lb_p_ready & run;
  assign in_hs      = s_valid & s_ready;

  // Priming kernels are swallowed; forwarded ones obey downstream ready.
  assign lb_k_ready = active & (drop | m_ready);
  assign m_valid    = active & ~drop & lb_k_valid;
  assign out_hs     = lb_k_valid & lb_k_ready;
  assign m_kernel   = lb_kernel;
  assign m_border   = m_valid & (out_col_q < BORDER_COLS);
  assign m_last     = m_valid & out_at_last;

  assign busy       = active;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (in_hs && in_at_last) begin
          state_d = (out_hs && out_at_last) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs && out_at_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (state_q == S_IDLE) begin
      in_col_d  = '0;
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end else begin
      if (in_hs) begin
        if (in_col_q == COL_LAST) begin
          in_col_d = '0;
          in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_ONE;
        end else begin
          in_col_d = in_col_q + COL_ONE;
        end
      end
      if (out_hs) begin
        if (out_col_q == COL_LAST) begin
          out_col_d = '0;
          out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_ONE;
        end else begin
          out_col_d = out_col_q + COL_ONE;
        end
      end
    end
  end

  // frame_done mirrors the DONE state one-for-one, from a flop.
  assign frame_done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lin_buff_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lin_buff_ctrl : randomized bench for lin_buff_ctrl with a lin_buff stand-in
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_lin_buff_ctrl;

  localparam int PW = 8;
  localparam int BW = 3;
  localparam int BH = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int KW = BW * BH * PW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_pixel;
  logic          lb_p_valid;
  logic          lb_p_ready;
  logic [PW-1:0] lb_pixel;
  logic          lb_k_valid;
  logic          lb_k_ready;
  logic [KW-1:0] lb_kernel;
  logic          m_valid;
  logic          m_ready;
  logic [KW-1:0] m_kernel;
  logic          m_border;
  logic          m_last;

  lin_buff_ctrl #(
    .PIXEL_WIDTH (PW),
    .BLOCK_WIDTH (BW),
    .BLOCK_HEIGHT(BH),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .lb_p_valid (lb_p_valid),
    .lb_p_ready (lb_p_ready),
    .lb_pixel   (lb_pixel),
    .lb_k_valid (lb_k_valid),
    .lb_k_ready (lb_k_ready),
    .lb_kernel  (lb_kernel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_kernel   (m_kernel),
    .m_border   (m_border),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // lin_buff stand-in: one kernel per accepted pixel, in order, 4-deep.
  // Kernel payload = {pixel, pixel index within the frame}.
  logic [15:0] sb_idx [4];
  logic [7:0]  sb_pix [4];
  int sb_wr, sb_rd, sb_cnt, sb_next;
  logic force_kv;

  assign lb_p_ready = (sb_cnt < 4);
  assign lb_k_valid = (sb_cnt != 0) || force_kv;
  assign lb_kernel  = (sb_cnt != 0) ? KW'({sb_pix[sb_rd], sb_idx[sb_rd]}) : '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_wr <= 0; sb_rd <= 0; sb_cnt <= 0; sb_next <= 0;
    end else begin
      if (lb_p_valid && lb_p_ready) begin
        sb_idx[sb_wr] <= 16'(sb_next);
        sb_pix[sb_wr] <= lb_pixel;
        sb_wr   <= (sb_wr + 1) % 4;
        sb_next <= (sb_next == W*H-1) ? 0 : sb_next + 1;
      end
      if (lb_k_ready && sb_cnt != 0) sb_rd <= (sb_rd + 1) % 4;
      sb_cnt <= sb_cnt + ((lb_p_valid && lb_p_ready) ? 1 : 0)
                       - ((lb_k_ready && sb_cnt != 0) ? 1 : 0);
    end
  end

  // Observation record, sampled mid-cycle.
  int   n_acc, n_kh, n_fd, last_cyc, fd_cyc;
  int   got_idx [$];
  bit   got_b [$];
  bit   got_l [$];
  logic [7:0] got_pix [$];
  logic [7:0] pix_q [$];
  int   exp_idx [$];
  int   n_checks = 0;
  int   n_pass = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (s_valid && s_ready) begin n_acc++; pix_q.push_back(s_pixel); end
      if (lb_k_valid && lb_k_ready) n_kh++;
      if (m_valid && m_ready) begin
        got_idx.push_back(int'(m_kernel[15:0]));
        got_pix.push_back(m_kernel[23:16]);
        got_b.push_back(m_border);
        got_l.push_back(m_last);
        if (m_last) last_cyc = cyc;
      end
      if (frame_done) begin n_fd++; fd_cyc = cyc; end
    end
  end

  task automatic clear_mon;
    n_acc = 0; n_kh = 0; n_fd = 0; last_cyc = -1; fd_cyc = -5;
    got_idx.delete(); got_b.delete(); got_l.delete(); got_pix.delete(); pix_q.delete();
  endtask

  // Scenario flags filled in by the frame driver.
  bit p1, p2, stalled, snap_ok, stall_bad, sready_fell;
  logic [KW-1:0] snap_k;
  logic snap_b;

  // mode 0: continuous, 1: 5-cycle s_valid gap, 2: 10-cycle m_ready stall,
  // 3: random valid/ready, 4: start pulses in RUN and DRAIN
  task automatic drive_frame(input int mode, output bit tmo);
    int stall, off, c;
    bit done, toggled;
    stall = 0; off = 0; done = 0; toggled = 0;
    p1 = 0; p2 = 0; stalled = 0; snap_ok = 0; stall_bad = 0; sready_fell = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (!done && c < 3000) begin
      start = 1'b0;
      s_valid = 1'b1;
      m_ready = 1'b1;
      case (mode)
        1: begin
          if (!toggled && n_acc == 12) begin off = 5; toggled = 1; end
          s_valid = (off == 0);
          if (off > 0) off--;
        end
        2: begin
          if (!stalled && got_idx.size() == 5) begin stall = 10; stalled = 1; end
          m_ready = (stall == 0);
        end
        3: begin
          s_valid = ($urandom % 4) != 0;
          m_ready = ($urandom % 4) != 0;
        end
        4: begin
          if (!p1 && n_acc == 10) begin start = 1'b1; p1 = 1; end
          else if (!p2 && n_acc == W*H && busy) begin start = 1'b1; p2 = 1; end
        end
        default: ;
      endcase
      s_pixel = PW'($urandom);
      @(negedge clk);
      if (stall > 0) begin
        if (!snap_ok) begin
          if (m_valid) begin snap_ok = 1; snap_k = m_kernel; snap_b = m_border; end
        end else if (!m_valid || m_kernel !== snap_k || m_border !== snap_b) begin
          stall_bad = 1;
        end
        if (!s_ready) sready_fell = 1;
        stall--;
      end
      if (frame_done) done = 1;
      else begin @(posedge clk); #1; end
      c++;
    end
    #1;
    tmo = !done;
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset;
    s_valid = 1'b1; m_ready = 1'b1; force_kv = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else n_pass++;
    n_checks++; if (s_ready !== 1'b0)    $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
    n_checks++; if (lb_p_valid !== 1'b0) $display("FAIL rst_lb_p_valid: got %b want 0", lb_p_valid); else n_pass++;
    n_checks++; if (lb_k_ready !== 1'b0) $display("FAIL rst_lb_k_ready: got %b want 0", lb_k_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0)    $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (m_border !== 1'b0)   $display("FAIL rst_m_border: got %b want 0", m_border); else n_pass++;
    n_checks++; if (m_last !== 1'b0)     $display("FAIL rst_m_last: got %b want 0", m_last); else n_pass++;
    s_valid = 1'b0; m_ready = 1'b0; force_kv = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_idle_gating;
    clear_mon;
    s_valid = 1'b1; force_kv = 1'b1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (s_ready !== 1'b0)    $display("FAIL idle_s_ready: got %b want 0", s_ready); else n_pass++;
    n_checks++; if (lb_p_valid !== 1'b0) $display("FAIL idle_lb_p_valid: got %b want 0", lb_p_valid); else n_pass++;
    n_checks++; if (lb_k_ready !== 1'b0) $display("FAIL idle_lb_k_ready: got %b want 0", lb_k_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0)    $display("FAIL idle_m_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    #1;
    n_checks++; if (n_acc !== 0)         $display("FAIL idle_consumed: got %0d want 0", n_acc); else n_pass++;
    s_valid = 1'b0; force_kv = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream(input int mode, input string nm);
    bit tmo;
    int nb;
    clear_mon;
    drive_frame(mode, tmo);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tmo !== 1'b0)   $display("FAIL %s_timeout: got %b want 0", nm, tmo); else n_pass++;
    n_checks++; if (n_acc !== W*H)  $display("FAIL %s_pixels: got %0d want %0d", nm, n_acc, W*H); else n_pass++;
    n_checks++; if (n_kh !== W*H)   $display("FAIL %s_lb_kernels: got %0d want %0d", nm, n_kh, W*H); else n_pass++;
    n_checks++; if (got_idx.size() !== exp_idx.size())
      $display("FAIL %s_fwd_count: got %0d want %0d", nm, got_idx.size(), exp_idx.size()); else n_pass++;
    nb = 0;
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      int i;
      bit eb, el;
      i  = exp_idx[j];
      eb = ((i % W) < BW-1);
      el = (i == W*H-1);
      n_checks++; if (got_idx[j] !== i) $display("FAIL %s_idx[%0d]: got %0d want %0d", nm, j, got_idx[j], i); else n_pass++;
      n_checks++; if (got_b[j] !== eb)  $display("FAIL %s_border[%0d]: got %0b want %0b", nm, j, got_b[j], eb); else n_pass++;
      n_checks++; if (got_l[j] !== el)  $display("FAIL %s_last[%0d]: got %0b want %0b", nm, j, got_l[j], el); else n_pass++;
      if (i < pix_q.size()) begin
        n_checks++; if (got_pix[j] !== pix_q[i])
          $display("FAIL %s_pixel[%0d]: got %0h want %0h", nm, j, got_pix[j], pix_q[i]); else n_pass++;
      end
      if (got_b[j]) nb++;
    end
    n_checks++; if (nb !== (BW-1)*(H-BH+1)) $display("FAIL %s_border_total: got %0d want %0d", nm, nb, (BW-1)*(H-BH+1)); else n_pass++;
    n_checks++; if (n_fd !== 1) $display("FAIL %s_done_pulses: got %0d want 1", nm, n_fd); else n_pass++;
    n_checks++; if (fd_cyc !== last_cyc + 1) $display("FAIL %s_done_timing: got cycle %0d want %0d", nm, fd_cyc, last_cyc + 1); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", nm, busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    bit tmo;
    clear_mon;
    drive_frame(2, tmo);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tmo !== 1'b0)        $display("FAIL bp_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (stalled !== 1'b1)    $display("FAIL bp_stall_applied: got %b want 1", stalled); else n_pass++;
    n_checks++; if (snap_ok !== 1'b1)    $display("FAIL bp_valid_seen: got %b want 1", snap_ok); else n_pass++;
    n_checks++; if (stall_bad !== 1'b0)  $display("FAIL bp_held_stable: got %b want 0", stall_bad); else n_pass++;
    n_checks++; if (sready_fell !== 1'b1) $display("FAIL bp_s_ready_fell: got %b want 1", sready_fell); else n_pass++;
    n_checks++; if (got_idx.size() !== exp_idx.size())
      $display("FAIL bp_fwd_count: got %0d want %0d", got_idx.size(), exp_idx.size()); else n_pass++;
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      n_checks++; if (got_idx[j] !== exp_idx[j])
        $display("FAIL bp_idx[%0d]: got %0d want %0d", j, got_idx[j], exp_idx[j]); else n_pass++;
    end
    n_checks++; if (n_fd !== 1) $display("FAIL bp_done_pulses: got %0d want 1", n_fd); else n_pass++;
  endtask

  task automatic test_start_ignored;
    bit tmo;
    clear_mon;
    drive_frame(4, tmo);
    n_checks++; if (tmo !== 1'b0) $display("FAIL startign_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (p1 !== 1'b1)  $display("FAIL startign_run_pulse: got %b want 1", p1); else n_pass++;
    n_checks++; if (p2 !== 1'b1)  $display("FAIL startign_drain_pulse: got %b want 1", p2); else n_pass++;
    n_checks++; if (got_idx.size() !== exp_idx.size())
      $display("FAIL startign_fwd_count: got %0d want %0d", got_idx.size(), exp_idx.size()); else n_pass++;
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      n_checks++; if (got_idx[j] !== exp_idx[j])
        $display("FAIL startign_idx[%0d]: got %0d want %0d", j, got_idx[j], exp_idx[j]); else n_pass++;
    end
    n_checks++; if (n_fd !== 1) $display("FAIL startign_done_pulses: got %0d want 1", n_fd); else n_pass++;
    // Second frame armed in the IDLE cycle right after DONE.
    clear_mon;
    drive_frame(0, tmo);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tmo !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (n_acc !== W*H) $display("FAIL b2b_pixels: got %0d want %0d", n_acc, W*H); else n_pass++;
    n_checks++; if (got_idx.size() !== exp_idx.size())
      $display("FAIL b2b_fwd_count: got %0d want %0d", got_idx.size(), exp_idx.size()); else n_pass++;
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      n_checks++; if (got_idx[j] !== exp_idx[j])
        $display("FAIL b2b_idx[%0d]: got %0d want %0d", j, got_idx[j], exp_idx[j]); else n_pass++;
    end
    n_checks++; if (n_fd !== 1)    $display("FAIL b2b_done_pulses: got %0d want 1", n_fd); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    bit tmo;
    int guard;
    clear_mon;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    guard = 0;
    while (n_acc < 20 && guard < 200) begin @(posedge clk); #1; guard++; end
    n_checks++; if (n_acc !== 20) $display("FAIL midrst_reach_pixel20: got %0d want 20", n_acc); else n_pass++;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)       $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (s_ready !== 1'b0)    $display("FAIL midrst_s_ready: got %b want 0", s_ready); else n_pass++;
    n_checks++; if (lb_p_valid !== 1'b0) $display("FAIL midrst_lb_p_valid: got %b want 0", lb_p_valid); else n_pass++;
    n_checks++; if (lb_k_ready !== 1'b0) $display("FAIL midrst_lb_k_ready: got %b want 0", lb_k_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0)    $display("FAIL midrst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (m_border !== 1'b0)   $display("FAIL midrst_m_border: got %b want 0", m_border); else n_pass++;
    n_checks++; if (m_last !== 1'b0)     $display("FAIL midrst_m_last: got %b want 0", m_last); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL midrst_frame_done: got %b want 0", frame_done); else n_pass++;
    s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    clear_mon;
    drive_frame(0, tmo);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tmo !== 1'b0) $display("FAIL midrst_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (n_acc !== W*H) $display("FAIL midrst_pixels: got %0d want %0d", n_acc, W*H); else n_pass++;
    n_checks++; if (got_idx.size() !== exp_idx.size())
      $display("FAIL midrst_fwd_count: got %0d want %0d", got_idx.size(), exp_idx.size()); else n_pass++;
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      n_checks++; if (got_idx[j] !== exp_idx[j])
        $display("FAIL midrst_idx[%0d]: got %0d want %0d", j, got_idx[j], exp_idx[j]); else n_pass++;
    end
    n_checks++; if (n_fd !== 1) $display("FAIL midrst_done_pulses: got %0d want 1", n_fd); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixel = '0; m_ready = 1'b0; force_kv = 1'b0;
    clear_mon;
    // Reference: kernel i is forwarded once its window has a full block of rows.
    for (int i = 0; i < W*H; i++) if (i / W >= BH-1) exp_idx.push_back(i);
    test_reset;
    test_idle_gating;
    test_stream(0, "cont");
    test_stream(1, "toggle");
    test_stream(3, "random");
    test_backpressure;
    test_start_ignored;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lin_buff_ctrl.md
Name: lin_buff_ctrl

Overview:
- Frame-level sequencer wrapped around lin_buff: gates the pixel stream into the line buffer for one frame of IMG_WIDTH x IMG_HEIGHT pixels.
- Tracks the image position of every kernel lin_buff emits. Drops priming kernels, tags row-wrapped kernels as border, marks the last kernel, and signals frame completion to the HOG pipeline downstream.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel (matches lin_buff BUFFER_WIDTH).
- BLOCK_WIDTH, 3, kernel columns.
- BLOCK_HEIGHT, 3, kernel rows.
- IMG_WIDTH, 8, pixels per row (>= BLOCK_WIDTH).
- IMG_HEIGHT, 6, rows per frame (>= BLOCK_HEIGHT).
- KERNEL_WIDTH, BLOCK_WIDTH*BLOCK_HEIGHT*PIXEL_WIDTH, kernel bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin-frame request, sampled only in IDLE.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse after the last kernel handshake.
- s_valid  in  1  source pixel valid.
- s_ready  out  1  source pixel ready.
- s_pixel  in  PIXEL_WIDTH  source pixel.
- lb_p_valid  out  1  to lin_buff p_valid.
- lb_p_ready  in  1  from lin_buff p_ready.
- lb_pixel  out  PIXEL_WIDTH  to lin_buff pixel.
- lb_k_valid  in  1  from lin_buff k_valid.
- lb_k_ready  out  1  to lin_buff k_ready.
- lb_kernel  in  KERNEL_WIDTH  from lin_buff kernel.
- m_valid  out  1  downstream kernel valid.
- m_ready  in  1  downstream kernel ready.
- m_kernel  out  KERNEL_WIDTH  forwarded kernel (equal to lb_kernel).
- m_border  out  1  kernel wraps across a row edge.
- m_last  out  1  last kernel of the frame.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN -> DRAIN on the last input handshake (in_row=IMG_HEIGHT-1, in_col=IMG_WIDTH-1).
  - DRAIN -> DONE on the output-side handshake at out_row=IMG_HEIGHT-1, out_col=IMG_WIDTH-1.
  - DONE -> IDLE unconditionally; DONE lasts exactly one cycle.
  - If the last output handshake happens in the same cycle as the last input handshake, go RUN -> DONE directly.
- Input gating is combinational, zero latency:
  - lb_pixel=s_pixel.
  - lb_p_valid = s_valid & (state==RUN).
  - s_ready = lb_p_ready & (state==RUN).
- Input counters: in_col wraps at IMG_WIDTH-1 and increments in_row. Both advance on s_valid&s_ready only.
- lin_buff contract: lin_buff emits exactly one kernel per accepted pixel, in order. Kernel index i corresponds to the window whose bottom-right pixel is (out_row, out_col).
- Output counters: out_col/out_row advance on each output-side handshake (lb_k_valid&lb_k_ready), in RUN or DRAIN only.
- Drop region, out_row < BLOCK_HEIGHT-1:
  - lb_k_ready=1, m_valid=0.
  - The kernel is consumed and discarded.
- Forward region, out_row >= BLOCK_HEIGHT-1:
  - m_valid=lb_k_valid and lb_k_ready=m_ready.
  - m_border = (out_col < BLOCK_WIDTH-1).
  - m_last = (out_row==IMG_HEIGHT-1 && out_col==IMG_WIDTH-1).
- Outside RUN/DRAIN: lb_k_ready=0, m_valid=0.
- m_border/m_last are combinational from the registered counters. They are valid only while m_valid=1 and are held stable under m_valid&!m_ready.
- Forwarded kernels per frame: (IMG_HEIGHT-BLOCK_HEIGHT+1)*IMG_WIDTH. Of these, (BLOCK_WIDTH-1)*(IMG_HEIGHT-BLOCK_HEIGHT+1) are border.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT), minimum 1. Compare with exact terminal values; no overflow is possible.
- frame_done is registered: high in the DONE cycle only.
- busy = (state==RUN || state==DRAIN).
- start is ignored outside IDLE. start held high re-arms immediately in the IDLE cycle after DONE.
- Reset (rst=0, any time including mid-frame) asynchronously:
  - state=IDLE, all counters=0, frame_done=0.
  - busy, s_ready, lb_p_valid, lb_k_ready, m_valid, m_border and m_last are all 0.
  - lin_buff shares this reset, so no partial-frame state survives.
- Back-pressure: m_ready=0 in the forward region holds lb_k_ready=0, which stalls lin_buff and in turn s_ready. No kernel is lost or duplicated.

Test Plan:
- Reset, then start with s_valid=1 and m_ready=1 continuously, lin_buff defaults (W=8, H=6):
  - 48 pixels accepted, 32 m_valid handshakes.
  - First forward is lb kernel index 16 with m_border=1.
  - 8 border kernels at out_col 0,1 of rows 2..5.
  - m_last only on handshake 32; frame_done 1 cycle later, single pulse; busy low afterwards.
- Same frame with s_valid toggled (5 cycles off mid-row, as in the lin_buff bench):
  - Counters freeze while s_valid=0.
  - Identical 32-kernel sequence and border pattern.
- m_ready low for 10 cycles at forwarded kernel 5:
  - m_valid held, m_kernel/m_border stable, s_ready falls once lin_buff fills.
  - No loss: total handshakes still 32.
- Pulse start during RUN and during DRAIN -> ignored, no counter reset. start in the IDLE cycle after DONE -> second frame runs with identical results.
- Assert rst=0 at pixel 20:
  - All outputs 0 asynchronously, before the next clk edge.
  - After release with start: clean frame, 32 kernels.
- s_valid=1 while in IDLE -> s_ready=0, lb_p_valid=0, no pixel consumed. lb_k_valid forced to 1 in IDLE -> lb_k_ready=0, m_valid=0.
